hilo_divider: RTL and testbench

Multi-cycle division unit and HI/LO register pair for the execute stage, sitting directly downstream of the ALU operand path. It replaces single-cycle combinational division with an iterative 32-step restoring divider and owns the architectural HI/LO registers written by DIV/DIVU/MTHI/MTLO and read by MFHI/MFLO. `busy` drives the pipeline stall logic.

---
 rtl/hilo_divider.sv | 142 ++++++++++++++
 tb/tb_hilo_divider.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/hilo_divider.sv
// hilo_divider: iterative restoring divider that owns the HI/LO register pair.
// DIV/DIVU take WIDTH+1 cycles from the start edge, and MTHI/MTLO write directly.
// A write strobe during a division aborts it, and the write is applied instead.
module hilo_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             write_hi,
  input  logic             write_lo,
  input  logic [WIDTH-1:0] write_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;
  logic             dz;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             wr;

  // Operand magnitudes and the restoring trial subtraction for one step.
  always_comb begin
    dvd_mag = dividend;
    dvs_mag = divisor;
    if (is_signed && dividend[WIDTH-1]) dvd_mag = -dividend;
    if (is_signed && divisor[WIDTH-1])  dvs_mag = -divisor;
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvsr};
    wr      = write_hi | write_lo;
  end

  // Control FSM, datapath, and the HI/LO registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dvsr        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (write_hi) hi <= write_data;
      if (write_lo) lo <= write_data;
      case (state)
        IDLE: begin
          if (start && !wr) begin
            busy <= 1'b1;
            if (divisor == '0) begin
              // Divide by zero bypasses RUN. The preset quotient and the raw
              // dividend in rem then fall through the normal FINISH write.
              state <= FINISH;
              rem   <= dividend;
              quo   <= '1;
              dvsr  <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              dz    <= 1'b1;
              cnt   <= '0;
            end else begin
              state <= RUN;
              rem   <= '0;
              quo   <= dvd_mag;
              dvsr  <= dvs_mag;
              neg_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              neg_r <= is_signed & dividend[WIDTH-1];
              dz    <= 1'b0;
              cnt   <= CNT_INIT;
            end
          end
        end
        RUN: begin
          if (wr) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            if (!diff[WIDTH]) begin
              rem <= diff[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
              rem <= shifted[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) state <= FINISH;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!wr) begin
            lo          <= neg_q ? -quo : quo;
            hi          <= neg_r ? -rem : rem;
            done        <= 1'b1;
            div_by_zero <= dz;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_divider.sv
// tb_hilo_divider: directed vectors for hilo_divider with hand-computed results.
module tb_hilo_divider;

  logic        clock;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        write_hi;
  logic        write_lo;
  logic [31:0] write_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  hilo_divider #(.WIDTH(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .write_hi    (write_hi),
    .write_lo    (write_lo),
    .write_data  (write_data),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one division and follow it to done, checking latency, busy span and results.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] dvd,
                         input logic [31:0] dvs, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input int exp_lat, input logic exp_dz);
    int lat;
    int busy_cycles;
    logic seen;
    @(negedge clock);
    start = 1'b1; is_signed = sgn; dividend = dvd; divisor = dvs;
    @(negedge clock);
    start = 1'b0;
    busy_cycles = busy ? 1 : 0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clock);
      lat++;
      if (done) seen = 1'b1;
      else if (busy) busy_cycles++;
    end
    check({tag, " done"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy span"}, 32'(busy_cycles), 32'(exp_lat));
    check({tag, " busy at done"}, 32'(busy), 32'd0);
    check({tag, " dz"}, 32'(div_by_zero), 32'(exp_dz));
    check({tag, " lo"}, lo, exp_lo);
    check({tag, " hi"}, hi, exp_hi);
    @(negedge clock);
    check({tag, " done pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int ndone;
    reset = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    write_hi = 1'b0; write_lo = 1'b0; write_data = '0;
    repeat (2) @(negedge clock);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    run_div("u100/7",    1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33, 1'b0);
    run_div("s-7/2",     1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   33, 1'b0);
    run_div("s7/-2",     1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          33, 1'b0);
    run_div("uFFF9/2",   1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          33, 1'b0);
    run_div("s ovf",     1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          33, 1'b0);
    run_div("u 8000/-1", 1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   33, 1'b0);
    run_div("dz",        1'b0, 32'h1234,       32'd0,          32'hFFFFFFFF,   32'h1234,       1,  1'b1);
    run_div("s dz",      1'b1, 32'hFFFFFF00,   32'd0,          32'hFFFFFFFF,   32'hFFFFFF00,   1,  1'b1);

    // Start together with both write strobes in IDLE: writes win, no division.
    @(negedge clock);
    start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    write_hi = 1'b1; write_lo = 1'b1; write_data = 32'h1234;
    @(negedge clock);
    start = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
    check("wr+start busy", 32'(busy), 32'd0);
    check("wr+start hi", hi, 32'h1234);
    check("wr+start lo", lo, 32'h1234);
    repeat (3) @(negedge clock);
    check("wr+start idle", 32'(busy), 32'd0);

    // Abort: ignored restart at cycle 10, MTLO at cycle 20, never a done.
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(negedge clock);
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c < 20; c++) begin
      if (c == 10) begin start = 1'b1; dividend = 32'd5; divisor = 32'd1; end
      else start = 1'b0;
      @(negedge clock);
      if (done) ndone++;
    end
    check("abort busy before", 32'(busy), 32'd1);
    write_lo = 1'b1; write_data = 32'hA5A5A5A5;
    @(negedge clock);
    write_lo = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort lo", lo, 32'hA5A5A5A5);
    check("abort hi", hi, 32'h1234);
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (done) ndone++;
    end
    check("abort no done", 32'(ndone), 32'd0);
    check("abort lo kept", lo, 32'hA5A5A5A5);

    // Asynchronous reset in the middle of RUN.
    start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("areset hi", hi, 32'd0);
    check("areset lo", lo, 32'd0);
    check("areset busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    run_div("u9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
